signed_div_seq: RTL and testbench
=================================

# signed_div_seq

Multi-cycle signed 32-bit divider controller for the multiply/divide unit. It drives two `make_positive` instances to take operand magnitudes and sequences a 32-iteration restoring unsigned divide over their outputs. A third `make_positive`-style negation stage restores the quotient and remainder signs. It flags divide-by-zero and the single overflow case, and pulses a ready strobe; it sits beside the multiplier under the `ctrl_DIV` decode.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state and outputs.
- `ctrl_DIV` in 1: start strobe, sampled each edge.
- `data_operandA` in WIDTH: signed dividend, sampled only on a start edge.
- `data_operandB` in WIDTH: signed divisor, sampled only on a start edge.
- `data_result` out WIDTH: signed quotient, truncated toward zero.
- `data_remainder` out WIDTH: signed remainder; its sign follows the dividend.
- `data_exception` out 1: divide-by-zero or overflow for the current result.
- `data_resultRDY` out 1: one-cycle strobe; outputs are valid while it is high and held until the next start.
- `busy` out 1: high while in RUN or FIX.

## Operation
- States: IDLE, RUN, FIX.
- Start edge (`ctrl_DIV`=1, any state):
  - Latch `signQ = A[31]^B[31]` and `signR = A[31]`.
  - Load `|A|` into Q and `|B|` into D via `make_positive` (enable = operand sign bit). `|−2^31|` = 0x80000000, treated as unsigned 2^31.
  - Clear R and count.
  - If B == 0, go to FIX with `zero_flag` set. Otherwise go to RUN.
- RUN, per edge:
  - Shift {R,Q} left by 1.
  - If R ≥ D, set R = R − D and Q[0] = 1.
  - count++. After the edge on which count reaches 31 (32nd RUN edge), go to FIX.
  - R is 33 bits wide internally for the compare/subtract.
- FIX, one edge, then return to IDLE:
  - `data_result` = signQ ? −Q : Q.
  - `data_remainder` = signR ? −R : R.
  - `data_exception` = zero_flag OR (A == 0x80000000 AND B == 0xFFFFFFFF).
  - Zero-divisor result: `data_result` = 0, `data_remainder` = 0.
  - Overflow result: `data_result` = 0x80000000 (the wrapped value), `data_remainder` = 0.
  - Assert `data_resultRDY` for the following cycle only.
- Start in RUN or FIX: aborts the current divide and restarts with the new operands. No RDY is produced for the aborted divide.
- `ctrl_DIV` held high: each edge restarts the divide, so the divide never completes.
- Outputs keep their last result values until the next FIX edge. A start edge clears `data_resultRDY` and `data_exception` but not `data_result` or `data_remainder`.

## Timing
- Edge 0 is the start edge.
- Nonzero divisor:
  - RUN edges 1–32, FIX edge 33.
  - `data_resultRDY` is high between edges 33 and 34.
  - Latency is 33 cycles.
- Zero divisor: FIX on edge 1, `data_resultRDY` high between edges 1 and 2.
- `busy` is high from after edge 0 until after the FIX edge.
- Reset (any state, including mid-RUN) takes effect on the next edge:
  - Next state is IDLE.
  - Outputs: `data_result`=0, `data_remainder`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
  - The in-flight divide is discarded.
- Reset and `ctrl_DIV` on the same edge: reset wins, and the start is ignored.

## Configuration
- `DIV_REMAINDER_EN` defined:
  - `data_remainder` is driven as specified.
  - The remainder negation stage and its register are instantiated.
- `DIV_REMAINDER_EN` undefined:
  - The `data_remainder` port remains, tied to 0.
  - The remainder register and its sign-fix logic are compiled out.
  - Quotient, exception and timing are unchanged.

## Test plan
- 100 / 7, start edge 0: RDY after edge 33, `data_result`=14, `data_remainder`=2, `data_exception`=0.
- −100 / 7 → −14 rem −2; 100 / −7 → −14 rem 2; −100 / −7 → 14 rem −2. All have `data_exception`=0.
- 7 / 0: RDY after edge 1, `data_result`=0, `data_remainder`=0, `data_exception`=1. Then 9 / 3 → 3, `data_exception`=0.
- 0x80000000 / 0xFFFFFFFF: `data_exception`=1, `data_result`=0x80000000. Then 0x80000000 / 2 → 0xC0000000 (−2^30), `data_exception`=0.
- Start 1000 / 10, restart at edge 10 with 50 / 6: a single RDY after edge 43 with 8 rem 2; no RDY near edge 33.
- Reset at edge 15 of a divide: all outputs are 0 and `busy`=0 after edge 15, and no RDY occurs. With `DIV_REMAINDER_EN` undefined, `data_remainder` stays 0 in all of the above.

Source files
------------

// File: rtl/signed_div_seq_if.sv
// Handshake and data bundle for the sequential signed divider.
// The master drives the start strobe and operands; the slave (divider) drives results and status.
interface signed_div_seq_if #(parameter int WIDTH = 32);
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic [WIDTH-1:0] data_remainder;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_remainder, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_remainder, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/signed_div_seq.sv
// Multi-cycle signed divider: operand magnitudes, 32-step restoring divide, sign fix-up.
// Define DIV_REMAINDER_EN to build the remainder register and its sign fix; otherwise data_remainder is tied to 0.
module make_positive #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] value,
   input  logic             enable,
   output logic [WIDTH-1:0] magnitude
);
   assign magnitude = enable ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
endmodule

// state | meaning
// IDLE  | waiting for ctrl_DIV; outputs hold the last result
// RUN   | one shift/subtract step per edge, WIDTH edges
// FIX   | apply signs, zero-divide and overflow handling, raise RDY
module signed_div_seq #(parameter int WIDTH = 32) (
   input logic              clock,
   input logic              reset,
   signed_div_seq_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_nxt;
   logic             busy;
   logic [WIDTH-1:0] q, d, r;
   logic [CNT_W-1:0] count;
   logic             sign_q, zero_flag, ovf_flag;
   logic [WIDTH-1:0] result;
   logic             exception, rdy;
   logic [WIDTH-1:0] mag_a, mag_b, q_signed;
   logic [WIDTH:0]   r_sh, diff;
   logic             start, divisor_zero;

   assign start        = bus.ctrl_DIV;
   assign divisor_zero = (bus.data_operandB == '0);

   make_positive #(.WIDTH(WIDTH)) u_pos_a (
      .value(bus.data_operandA), .enable(bus.data_operandA[WIDTH-1]), .magnitude(mag_a));
   make_positive #(.WIDTH(WIDTH)) u_pos_b (
      .value(bus.data_operandB), .enable(bus.data_operandB[WIDTH-1]), .magnitude(mag_b));
   make_positive #(.WIDTH(WIDTH)) u_neg_q (
      .value(q), .enable(sign_q), .magnitude(q_signed));

   // r < d <= 2^(WIDTH-1), so bit WIDTH of the difference is a clean borrow
   assign r_sh = {r, q[WIDTH-1]};
   assign diff = r_sh - {1'b0, d};

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         RUN: begin
            busy = 1'b1;
            if (count == CNT_LAST) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: ;
      endcase
      if (start) state_nxt = divisor_zero ? FIX : RUN;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q         <= '0;
         d         <= '0;
         r         <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         zero_flag <= 1'b0;
         ovf_flag  <= 1'b0;
         result    <= '0;
         exception <= 1'b0;
         rdy       <= 1'b0;
      end else begin
         rdy <= 1'b0;
         if (start) begin
            q         <= mag_a;
            d         <= mag_b;
            r         <= '0;
            count     <= '0;
            sign_q    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            zero_flag <= divisor_zero;
            ovf_flag  <= (bus.data_operandA == MOST_NEG) && (bus.data_operandB == '1);
            exception <= 1'b0;
         end else if (state == RUN) begin
            count <= count + 1'b1;
            if (!diff[WIDTH]) begin
               r <= diff[WIDTH-1:0];
               q <= {q[WIDTH-2:0], 1'b1};
            end else begin
               r <= r_sh[WIDTH-1:0];
               q <= {q[WIDTH-2:0], 1'b0};
            end
         end else if (state == FIX) begin
            // overflow needs no special case: |MOST_NEG|/1 with positive sign wraps to MOST_NEG
            result    <= zero_flag ? '0 : q_signed;
            exception <= zero_flag | ovf_flag;
            rdy       <= 1'b1;
         end
      end
   end

`ifdef DIV_REMAINDER_EN
   logic             sign_r;
   logic [WIDTH-1:0] r_signed, remainder;

   make_positive #(.WIDTH(WIDTH)) u_neg_r (
      .value(r), .enable(sign_r), .magnitude(r_signed));

   always_ff @(posedge clock) begin
      if (reset) begin
         sign_r    <= 1'b0;
         remainder <= '0;
      end else if (start) begin
         sign_r <= bus.data_operandA[WIDTH-1];
      end else if (state == FIX) begin
         remainder <= zero_flag ? '0 : r_signed;
      end
   end

   assign bus.data_remainder = remainder;
`else
   assign bus.data_remainder = '0;
`endif

   assign bus.data_result    = result;
   assign bus.data_exception = exception;
   assign bus.data_resultRDY = rdy;
   assign bus.busy           = busy;
endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq: directed cases, random operands against a
// 64-bit arithmetic reference, restart and reset-mid-divide scenarios.
module tb_signed_div_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_check = 0;
   int   n_pass  = 0;
   logic [31:0] prev_q = '0;
   logic [31:0] prev_r = '0;

   signed_div_seq_if #(.WIDTH(32)) bus ();

   signed_div_seq #(.WIDTH(32)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_check++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic exc, output int lat);
      longint sa, sb, q64, r64;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         q = '0; r = '0; exc = 1'b1; lat = 1;
      end else begin
         q64 = sa / sb;
         r64 = sa % sb;
         q   = q64[31:0];
         r   = r64[31:0];
         exc = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
         lat = 33;
      end
`ifndef DIV_REMAINDER_EN
      r = '0;
`endif
   endfunction

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clk);
      #1;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
   endtask

   task automatic wait_rdy(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      logic        ee;
      int          elat, lat;
      model(a, b, eq, er, ee, elat);
      start(a, b);
      check({tag, ".busy_start"}, {31'd0, bus.busy}, 32'd1);
      check({tag, ".exc_clr"}, {31'd0, bus.data_exception}, 32'd0);
      check({tag, ".q_hold"}, bus.data_result, prev_q);
      wait_rdy(lat);
      check({tag, ".latency"}, lat, elat);
      check({tag, ".quot"}, bus.data_result, eq);
      check({tag, ".rem"}, bus.data_remainder, er);
      check({tag, ".exc"}, {31'd0, bus.data_exception}, {31'd0, ee});
      check({tag, ".busy_done"}, {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, ".rdy_pulse"}, {31'd0, bus.data_resultRDY}, 32'd0);
      check({tag, ".q_held"}, bus.data_result, eq);
      check({tag, ".r_held"}, bus.data_remainder, er);
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      logic [31:0] a, b;
      int          lat, seen;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst.quot", bus.data_result, 32'd0);
      check("rst.rem", bus.data_remainder, 32'd0);
      check("rst.exc", {31'd0, bus.data_exception}, 32'd0);
      check("rst.rdy", {31'd0, bus.data_resultRDY}, 32'd0);
      check("rst.busy", {31'd0, bus.busy}, 32'd0);

      run_div("p_p", 32'd100, 32'd7);
      run_div("n_p", -32'sd100, 32'd7);
      run_div("p_n", 32'd100, -32'sd7);
      run_div("n_n", -32'sd100, -32'sd7);
      run_div("div0", 32'd7, 32'd0);
      run_div("after0", 32'd9, 32'd3);
      run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("min_2", 32'h8000_0000, 32'd2);
      run_div("min_min", 32'h8000_0000, 32'h8000_0000);
      run_div("max_min", 32'h7FFF_FFFF, 32'h8000_0000);
      run_div("zero_n", 32'd0, -32'sd5);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 20);
            2:       b = -$urandom_range(1, 20);
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
         run_div($sformatf("rnd%0d", i), a, b);
      end

      // abort 1000/10 at edge 10 with 50/6; only one RDY, after edge 43
      start(32'd1000, 32'd10);
      seen = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) seen++;
      end
      check("abort.no_rdy", seen, 0);
      start(32'd50, 32'd6);
      wait_rdy(lat);
      check("restart.latency", lat, 33);
      check("restart.quot", bus.data_result, 32'd8);
`ifdef DIV_REMAINDER_EN
      check("restart.rem", bus.data_remainder, 32'd2);
`else
      check("restart.rem", bus.data_remainder, 32'd0);
`endif
      prev_q = bus.data_result;

      // reset at edge 15 of a divide
      start(32'd5000, 32'd7);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst.quot", bus.data_result, 32'd0);
      check("midrst.rem", bus.data_remainder, 32'd0);
      check("midrst.exc", {31'd0, bus.data_exception}, 32'd0);
      check("midrst.rdy", {31'd0, bus.data_resultRDY}, 32'd0);
      check("midrst.busy", {31'd0, bus.busy}, 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) seen++;
      end
      check("midrst.no_rdy", seen, 0);
      prev_q = '0;
      prev_r = '0;

      // reset and start on the same edge: start ignored
      rst               = 1'b1;
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd77;
      bus.data_operandB = 32'd0;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.ctrl_DIV = 1'b0;
      check("rst_start.busy", {31'd0, bus.busy}, 32'd0);
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) seen++;
      end
      check("rst_start.no_rdy", seen, 0);

      run_div("final", 32'd12345, -32'sd100);

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end
endmodule
